// File: rtl/serial_pkg.sv
// Shared definitions for the serializer slice: FSM state encoding and default word width.
package serial_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Bit-position counter for the serializer: counts 0..WIDTH-1 and wraps on the last bit.
module bit_counter
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     en,
  output logic [$clog2(WIDTH)-1:0] count,
  output logic                     last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] MAX_COUNT = CW'(WIDTH - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign last  = (count_q == MAX_COUNT);
  assign count = count_q;

  // Clear has priority so a word accepted on the last-bit edge restarts at position 0.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = last ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready input and registered serial outputs.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             din_ready,
  output logic             so,
  output logic             so_valid,
  output logic             so_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             so_q, so_d;
  logic             so_valid_q, so_valid_d;
  logic             so_last_q, so_last_d;

  logic             accept;
  logic             cnt_en;
  logic [CW-1:0]    cnt_count;
  logic             cnt_last;

  bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk  (clk),
    .reset(reset),
    .clear(accept),
    .en   (cnt_en),
    .count(cnt_count),
    .last (cnt_last)
  );

  // Ready reopens during the last-bit cycle so a following word can start with no gap.
  assign din_ready = (state_q == IDLE) || so_last_q;
  assign accept    = din_valid && din_ready;

  // The bit on so is always the current end of the register; each shift exposes the next one.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    so_d       = 1'b0;
    so_valid_d = 1'b0;
    so_last_d  = 1'b0;
    cnt_en     = 1'b0;

    if (accept) begin
      state_d    = SHIFT;
      shreg_d    = din;
      so_d       = LSB_FIRST ? din[0] : din[WIDTH-1];
      so_valid_d = 1'b1;
    end else if (state_q == SHIFT) begin
      cnt_en = 1'b1;
      if (cnt_last) begin
        state_d = IDLE;
      end else begin
        shreg_d    = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
        so_d       = LSB_FIRST ? shreg_q[1] : shreg_q[WIDTH-2];
        so_valid_d = 1'b1;
        so_last_d  = (cnt_count == PENULT);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      so_q       <= 1'b0;
      so_valid_q <= 1'b0;
      so_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      so_q       <= so_d;
      so_valid_q <= so_valid_d;
      so_last_q  <= so_last_d;
    end
  end

  assign so       = so_q;
  assign so_valid = so_valid_q;
  assign so_last  = so_last_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: LSB-first and MSB-first instances plus a chained SIPO.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       dinValid;
  logic       dinValidB;
  logic [3:0] din;
  logic       dinReadyA, soA, soValidA, soLastA;
  logic       dinReadyB, soB, soValidB, soLastB;
  logic [3:0] sipo;

  typedef struct packed {
    logic b;
    logic last;
    logic first;
    logic contig;
  } exp_t;

  exp_t qA[$];
  logic qB[$];
  int   checks = 0;
  int   passes = 0;
  logic [3:0] hist;
  int   hcnt;
  logic prevValid;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dutA (
    .clk(clk), .reset(reset), .din_valid(dinValid), .din(din),
    .din_ready(dinReadyA), .so(soA), .so_valid(soValidA), .so_last(soLastA)
  );

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dutB (
    .clk(clk), .reset(reset), .din_valid(dinValidB), .din(din),
    .din_ready(dinReadyB), .so(soB), .so_valid(soValidB), .so_last(soLastB)
  );

  // Downstream serial-in register fed straight from the serializer output.
  always @(posedge clk or posedge reset) begin
    if (reset) sipo <= '0;
    else       sipo <= {sipo[2:0], soA};
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // seq lists the expected serial bits with the first-sent bit in seq[3].
  task automatic applyStimulus(input logic [3:0] w, input logic [3:0] seq, input bit contig,
                               output int waited, output logic lastAtAccept);
    bit got;
    dinValid = 1'b1;
    din      = w;
    for (int k = 0; k < 4; k++)
      qA.push_back(exp_t'{b: seq[3-k], last: (k == 3), first: (k == 0), contig: contig});
    waited       = 0;
    got          = 1'b0;
    lastAtAccept = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (dinReadyA) begin
        got          = 1'b1;
        lastAtAccept = soLastA;
      end else begin
        waited++;
      end
    end
    checkOutput("accept within bound", got, 1);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic expSo;
    if (reset) begin
      hist      = '0;
      hcnt      = 0;
      prevValid = 1'b0;
    end else begin
      expSo = 1'b0;
      if (soValidA) begin
        if (qA.size() == 0) begin
          checkOutput("unexpected so_valid", soValidA, 0);
        end else begin
          e = qA.pop_front();
          checkOutput("so bit", soA, e.b);
          checkOutput("so_last", soLastA, e.last);
          checkOutput("din_ready in word", dinReadyA, e.last);
          if (e.first && e.contig) checkOutput("no gap before word", prevValid, 1);
          expSo = e.b;
        end
      end else begin
        checkOutput("idle so/so_last", {soA, soLastA}, 0);
        checkOutput("idle din_ready", dinReadyA, 1);
      end
      if (hcnt >= 4) checkOutput("chained sipo out", sipo[3], hist[3]);
      hist = {hist[2:0], expSo};
      if (hcnt < 4) hcnt++;
      prevValid = soValidA;
    end
  end

  always @(negedge clk) begin
    if (!reset && soValidB) begin
      if (qB.size() == 0) checkOutput("B unexpected so_valid", soValidB, 0);
      else                checkOutput("B msb-first bit", soB, qB.pop_front());
    end
  end

  initial begin
    int   w;
    logic la;
    reset     = 1'b1;
    dinValid  = 1'b0;
    dinValidB = 1'b0;
    din       = 4'h0;
    #3;
    checkOutput("reset so/valid/last", {soA, soValidA, soLastA}, 0);
    checkOutput("reset din_ready", dinReadyA, 1);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;

    $display("[TB] single word, LSB first");
    applyStimulus(4'b1011, 4'b1101, 1'b0, w, la);
    dinValid = 1'b0;
    din      = 4'h0;
    checkOutput("first accept after reset", w, 0);
    repeat (6) @(posedge clk);
    #1;

    $display("[TB] single word, MSB first");
    din       = 4'b1011;
    dinValidB = 1'b1;
    qB.push_back(1'b1); qB.push_back(1'b0); qB.push_back(1'b1); qB.push_back(1'b1);
    @(posedge clk);
    #1;
    dinValidB = 1'b0;
    din       = 4'b0000;
    repeat (6) @(posedge clk);
    #1;

    $display("[TB] back-to-back words");
    applyStimulus(4'hA, 4'b0101, 1'b0, w, la);
    applyStimulus(4'h5, 4'b1010, 1'b1, w, la);
    dinValid = 1'b0;
    din      = 4'h0;
    repeat (8) @(posedge clk);
    #1;

    $display("[TB] hold-off during a word");
    applyStimulus(4'h3, 4'b1100, 1'b0, w, la);
    dinValid = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(4'hF, 4'b1111, 1'b1, w, la);
    dinValid = 1'b0;
    checkOutput("holdoff accepted on so_last", la, 1);
    checkOutput("holdoff wait cycles", w, 2);
    repeat (8) @(posedge clk);
    #1;

    $display("[TB] reset mid-word");
    applyStimulus(4'h6, 4'b0110, 1'b0, w, la);
    dinValid = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    qA.delete();
    #1;
    checkOutput("mid-word reset so/valid/last", {soA, soValidA, soLastA}, 0);
    checkOutput("mid-word reset din_ready", dinReadyA, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    applyStimulus(4'h9, 4'b1001, 1'b0, w, la);
    dinValid = 1'b0;
    checkOutput("accept on first edge after reset", w, 0);
    repeat (8) @(posedge clk);
    #1;

    checkOutput("scoreboard A drained", qA.size(), 0);
    checkOutput("scoreboard B drained", qB.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
